ahb_master_ls: RTL and testbench

Single-transfer AHB-Lite initiator that lets the CPU load/store unit issue loads and stores onto the AHB fabric toward the PS-side memory port. It is the requesting end of the same AHB link whose responder side serves load addresses and data to the Zynq master. It handles one outstanding NONSEQ SINGLE transfer at a time, slave wait states, two-cycle ERROR responses, byte/halfword lane steering and load sign extension.

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_master_ls_if.sv | 47 ++++
 rtl/ahb_lane_steer.sv | 57 +++++
 rtl/ahb_master_ls.sv | 153 +++++++++++++++
 tb/tb_ahb_master_ls.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared encodings for the single-transfer AHB-Lite initiator: bus codes,
// load/store request sizes and the controller state type.
package ahb_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] REQ_SIZE_BYTE = 2'b00;
    localparam logic [1:0] REQ_SIZE_HALF = 2'b01;
    localparam logic [1:0] REQ_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Legal request sizes map straight onto the low HSIZE bits.
    function automatic logic [2:0] req_to_hsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/ahb_master_ls_if.sv
// Bundle of the AHB-Lite master port plus the load/store request/response
// handshake; master is the initiator's view, slave is the environment's view.
interface ahb_master_ls_if
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] M_AHB_0_haddr;
    logic [2:0]        M_AHB_0_hburst;
    logic              M_AHB_0_hmastlock;
    logic [3:0]        M_AHB_0_hprot;
    logic [2:0]        M_AHB_0_hsize;
    logic [1:0]        M_AHB_0_htrans;
    logic              M_AHB_0_hwrite;
    logic [DATA_W-1:0] M_AHB_0_hwdata;
    logic [DATA_W-1:0] M_AHB_0_hrdata;
    logic              M_AHB_0_hready;
    logic              M_AHB_0_hresp;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output M_AHB_0_haddr, M_AHB_0_hburst, M_AHB_0_hmastlock, M_AHB_0_hprot,
               M_AHB_0_hsize, M_AHB_0_htrans, M_AHB_0_hwrite, M_AHB_0_hwdata,
        input  M_AHB_0_hrdata, M_AHB_0_hready, M_AHB_0_hresp,
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  M_AHB_0_haddr, M_AHB_0_hburst, M_AHB_0_hmastlock, M_AHB_0_hprot,
               M_AHB_0_hsize, M_AHB_0_htrans, M_AHB_0_hwrite, M_AHB_0_hwdata,
        output M_AHB_0_hrdata, M_AHB_0_hready, M_AHB_0_hresp,
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/ahb_lane_steer.sv
// Combinational byte-lane logic: request alignment check, store-data lane
// replication and little-endian load lane select with sign/zero extension.
module ahb_lane_steer
    import ahb_pkg::*;
(
    input  logic [1:0]        req_size,
    input  logic [1:0]        req_addr_lo,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_legal,
    output logic [DATA_W-1:0] wdata_rep,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_lane,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rdata_ext
);

    function automatic logic [DATA_W-1:0] extend8(input logic signed [7:0] v, input logic uns);
        logic signed [DATA_W-1:0] sx;
        sx = 32'(v);
        if (uns) return {24'h0, v};
        return sx;
    endfunction

    function automatic logic [DATA_W-1:0] extend16(input logic signed [15:0] v, input logic uns);
        logic signed [DATA_W-1:0] sx;
        sx = 32'(v);
        if (uns) return {16'h0, v};
        return sx;
    endfunction

    always_comb begin
        req_legal = 1'b0;
        wdata_rep = req_wdata;
        case (req_size)
            REQ_SIZE_BYTE: begin
                req_legal = 1'b1;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            REQ_SIZE_HALF: begin
                req_legal = ~req_addr_lo[0];
                wdata_rep = {2{req_wdata[15:0]}};
            end
            REQ_SIZE_WORD: req_legal = (req_addr_lo == 2'b00);
            default:       req_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (ld_size)
            REQ_SIZE_BYTE: rdata_ext = extend8(rdata[{ld_lane, 3'b000} +: 8], ld_unsigned);
            REQ_SIZE_HALF: rdata_ext = extend16(rdata[{ld_lane[1], 4'b0000} +: 16], ld_unsigned);
            default:       rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/ahb_master_ls.sv
// Single-outstanding AHB-Lite initiator for the CPU load/store unit: one
// NONSEQ SINGLE transfer at a time, wait states, two-cycle ERROR handling.
module ahb_master_ls
    import ahb_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic HCLK,
    input  logic rst,
    ahb_master_ls_if.master bus
);

    state_t            state, state_nx;
    logic              accept;
    logic              req_legal;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] rdata_ext;

    logic [1:0]        lane_p0;
    logic [1:0]        size_p0;
    logic              uns_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic [ADDR_W-1:0] haddr_d;
    logic [1:0]        htrans_d;
    logic              hwrite_d;
    logic [2:0]        hsize_d;
    logic [DATA_W-1:0] hwdata_d;
    logic              rsp_valid_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign accept                = bus.req_valid && bus.req_ready;
    assign bus.req_ready         = (state == ST_IDLE) && !rst;
    assign bus.busy              = (state != ST_IDLE);
    assign bus.M_AHB_0_hburst    = HBURST_SINGLE;
    assign bus.M_AHB_0_hmastlock = 1'b0;
    assign bus.M_AHB_0_hprot     = HPROT_VAL;

    ahb_lane_steer u_steer (
        .req_size    (bus.req_size),
        .req_addr_lo (bus.req_addr[1:0]),
        .req_wdata   (bus.req_wdata),
        .req_legal   (req_legal),
        .wdata_rep   (wdata_rep),
        .ld_size     (size_p0),
        .ld_lane     (lane_p0),
        .ld_unsigned (uns_p0),
        .rdata       (bus.M_AHB_0_hrdata),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge HCLK or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && req_legal) state_nx = ST_ADDR;
            ST_ADDR: if (bus.M_AHB_0_hready) state_nx = ST_DATA;
            ST_DATA: begin
                if (bus.M_AHB_0_hresp) state_nx = bus.M_AHB_0_hready ? ST_IDLE : ST_ERR;
                else if (bus.M_AHB_0_hready) state_nx = ST_IDLE;
            end
            ST_ERR:  if (bus.M_AHB_0_hready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        haddr_d     = bus.M_AHB_0_haddr;
        htrans_d    = bus.M_AHB_0_htrans;
        hwrite_d    = bus.M_AHB_0_hwrite;
        hsize_d     = bus.M_AHB_0_hsize;
        hwdata_d    = bus.M_AHB_0_hwdata;
        rsp_valid_d = 1'b0;
        rsp_err_d   = bus.rsp_err;
        rsp_rdata_d = bus.rsp_rdata;
        case (state)
            ST_IDLE: begin
                if (accept && req_legal) begin
                    haddr_d  = bus.req_addr;
                    htrans_d = HTRANS_NONSEQ;
                    hwrite_d = bus.req_write;
                    hsize_d  = req_to_hsize(bus.req_size);
                end else if (accept) begin
                    // Misaligned or illegal size: answer locally, bus stays idle.
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ST_ADDR: begin
                if (bus.M_AHB_0_hready) begin
                    htrans_d = HTRANS_IDLE;
                    if (bus.M_AHB_0_hwrite) hwdata_d = wdata_p0;
                end
            end
            ST_DATA: begin
                if (bus.M_AHB_0_hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.M_AHB_0_hresp;
                    rsp_rdata_d = (bus.M_AHB_0_hresp || bus.M_AHB_0_hwrite) ? '0 : rdata_ext;
                end
            end
            ST_ERR: begin
                if (bus.M_AHB_0_hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Request capture: lane info and steered store data for the later phases
    always_ff @(posedge HCLK) begin
        if (accept && req_legal) begin
            lane_p0  <= bus.req_addr[1:0];
            size_p0  <= bus.req_size;
            uns_p0   <= bus.req_unsigned;
            wdata_p0 <= wdata_rep;
        end
    end

    // Registered bus and response outputs
    always_ff @(posedge HCLK or posedge rst) begin
        if (rst) begin
            bus.M_AHB_0_haddr  <= '0;
            bus.M_AHB_0_htrans <= HTRANS_IDLE;
            bus.M_AHB_0_hwrite <= 1'b0;
            bus.M_AHB_0_hsize  <= HSIZE_WORD;
            bus.M_AHB_0_hwdata <= '0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_err        <= 1'b0;
            bus.rsp_rdata      <= '0;
        end else begin
            bus.M_AHB_0_haddr  <= haddr_d;
            bus.M_AHB_0_htrans <= htrans_d;
            bus.M_AHB_0_hwrite <= hwrite_d;
            bus.M_AHB_0_hsize  <= hsize_d;
            bus.M_AHB_0_hwdata <= hwdata_d;
            bus.rsp_valid      <= rsp_valid_d;
            bus.rsp_err        <= rsp_err_d;
            bus.rsp_rdata      <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_ls.sv
// Directed and randomized bench for ahb_master_ls with a transaction-level
// reference for alignment, lane replication and load extension.
module tb_ahb_master_ls;
    import ahb_pkg::*;

    logic HCLK;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ahb_master_ls_if #(.ADDR_W(32)) bus ();

    ahb_master_ls #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
        .HCLK (HCLK),
        .rst  (rst),
        .bus  (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    function automatic bit model_legal(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd3) return 1'b0;
        return (addr % (32'd1 << size)) == 0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [1:0] size);
        if (size == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns, input logic [31:0] rd);
        int          bits;
        logic [31:0] v;
        logic [31:0] mask;
        if (size == 2'd2) return rd;
        bits = (size == 2'd0) ? 8 : 16;
        v    = rd >> (8 * (addr % 4));
        mask = (32'd1 << bits) - 1;
        v    = v & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // err: 0 = OKAY, 1 = two-cycle ERROR, 2 = ERROR with hready already high
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int waits,
                        input int err, input logic [31:0] rd);
        int          lat;
        logic [31:0] exp_w;
        logic [31:0] exp_r;
        exp_w = model_wdata(wdata, size);
        exp_r = (wr || err != 0) ? 32'h0 : model_load(addr, size, uns, rd);
        chk("idle_req_ready", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.M_AHB_0_hready = 1'b1;
        bus.M_AHB_0_hresp  = 1'b0;
        step();
        lat = 0;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        if (!model_legal(addr, size)) begin
            chk("illegal_htrans", bus.M_AHB_0_htrans, HTRANS_IDLE);
            chk("illegal_rsp_valid", bus.rsp_valid, 1);
            chk("illegal_rsp_err", bus.rsp_err, 1);
            chk("illegal_rsp_rdata", bus.rsp_rdata, 0);
            chk("illegal_busy", bus.busy, 0);
            step();
            chk("illegal_htrans2", bus.M_AHB_0_htrans, HTRANS_IDLE);
            chk("illegal_rsp_clear", bus.rsp_valid, 0);
            return;
        end
        chk("addr_htrans", bus.M_AHB_0_htrans, HTRANS_NONSEQ);
        chk("addr_haddr", bus.M_AHB_0_haddr, addr);
        chk("addr_hsize", bus.M_AHB_0_hsize, {30'b0, size});
        chk("addr_hwrite", bus.M_AHB_0_hwrite, wr);
        chk("addr_busy", bus.busy, 1);
        chk("addr_req_ready", bus.req_ready, 0);
        step();
        lat++;
        chk("data_htrans", bus.M_AHB_0_htrans, HTRANS_IDLE);
        chk("data_rsp_valid", bus.rsp_valid, 0);
        if (wr) chk("data_hwdata", bus.M_AHB_0_hwdata, exp_w);
        for (int i = 0; i < waits; i++) begin
            bus.M_AHB_0_hready = 1'b0;
            bus.M_AHB_0_hresp  = 1'b0;
            bus.M_AHB_0_hrdata = $urandom;
            step();
            lat++;
            chk("wait_rsp_valid", bus.rsp_valid, 0);
            chk("wait_busy", bus.busy, 1);
            if (wr) chk("wait_hwdata", bus.M_AHB_0_hwdata, exp_w);
        end
        if (err == 1) begin
            bus.M_AHB_0_hready = 1'b0;
            bus.M_AHB_0_hresp  = 1'b1;
            step();
            lat++;
            chk("err1_htrans", bus.M_AHB_0_htrans, HTRANS_IDLE);
            chk("err1_rsp_valid", bus.rsp_valid, 0);
            if (wr) chk("err1_hwdata", bus.M_AHB_0_hwdata, exp_w);
            bus.M_AHB_0_hready = 1'b1;
            bus.M_AHB_0_hresp  = 1'b1;
            step();
            lat++;
        end else begin
            bus.M_AHB_0_hready = 1'b1;
            bus.M_AHB_0_hresp  = (err == 2);
            bus.M_AHB_0_hrdata = rd;
            step();
            lat++;
        end
        bus.M_AHB_0_hready = 1'b1;
        bus.M_AHB_0_hresp  = 1'b0;
        bus.M_AHB_0_hrdata = $urandom;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_err", bus.rsp_err, (err != 0));
        chk("rsp_rdata", bus.rsp_rdata, exp_r);
        chk("rsp_latency", lat, 2 + waits + ((err == 1) ? 1 : 0));
        chk("rsp_req_ready", bus.req_ready, 1);
        chk("rsp_htrans", bus.M_AHB_0_htrans, HTRANS_IDLE);
        step();
        chk("rsp_pulse_end", bus.rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.M_AHB_0_hrdata = '0;
        bus.M_AHB_0_hready = 1'b1;
        bus.M_AHB_0_hresp = 1'b0;
        step();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_haddr", bus.M_AHB_0_haddr, 0);
        chk("rst_htrans", bus.M_AHB_0_htrans, 0);
        chk("rst_hwrite", bus.M_AHB_0_hwrite, 0);
        chk("rst_hsize", bus.M_AHB_0_hsize, 3'b010);
        chk("rst_hwdata", bus.M_AHB_0_hwdata, 0);
        chk("rst_hburst", bus.M_AHB_0_hburst, 0);
        chk("rst_hmastlock", bus.M_AHB_0_hmastlock, 0);
        chk("rst_hprot", bus.M_AHB_0_hprot, 4'b0011);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("post_rst_req_ready", bus.req_ready, 1);
        step();

        xfer(1'b0, 32'h0000_1000, 32'h0, 2'd2, 1'b0, 0, 0, 32'hDEADBEEF);
        xfer(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b0, 0, 0, 32'h8012_3456);
        xfer(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b1, 0, 0, 32'h8012_3456);
        xfer(1'b1, 32'h0000_2002, 32'h1234_A55A, 2'd1, 1'b0, 3, 0, 32'h0);
        xfer(1'b0, 32'h0000_3000, 32'h0, 2'd2, 1'b0, 0, 1, 32'h1234_5678);
        xfer(1'b1, 32'h0000_4001, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 0, 32'h0);
        xfer(1'b0, 32'h0000_5006, 32'h0, 2'd1, 1'b0, 1, 0, 32'h9ABC_1234);
        xfer(1'b0, 32'h0000_6000, 32'h0, 2'd1, 1'b0, 0, 2, 32'h0);
        xfer(1'b0, 32'h0000_7000, 32'h0, 2'd3, 1'b0, 0, 0, 32'h0);

        // Reset while a load sits in its data phase with wait states
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_8004;
        bus.req_size  = 2'd2;
        step();
        bus.req_valid = 1'b0;
        step();
        bus.M_AHB_0_hready = 1'b0;
        step();
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_htrans", bus.M_AHB_0_htrans, 0);
        chk("mid_rst_haddr", bus.M_AHB_0_haddr, 0);
        chk("mid_rst_hsize", bus.M_AHB_0_hsize, 3'b010);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        bus.M_AHB_0_hready = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_rsp", bus.rsp_valid, 0);
        end
        xfer(1'b0, 32'h0000_8004, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0BAD_F00D);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          e;
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
            e = $urandom_range(0, 6);
            if (e > 2) e = 0;
            xfer(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), e, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
